uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 9, maximum data bits per frame (legal 5..12).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, >=2).
REQ-003 SHALL have port i_clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ce  input  1  bit-period tick; the FSM advances only when high.
REQ-006 SHALL have port i_data  input  DATA_W  frame data, LSB transmitted first.
REQ-007 SHALL have port i_wr  input  1  FIFO push strobe, sampled every clock regardless of i_ce.
REQ-008 SHALL have port i_length  input  3  data bits = 5 + i_length, clamped to DATA_W.
REQ-009 SHALL have port i_stop2  input  1  two stop bits when high.
REQ-010 SHALL have port i_parity  input  1  parity bit enable.
REQ-011 SHALL have port i_odd  input  1  odd parity when high, even when low.
REQ-012 SHALL have port i_break  input  1  break request (see Configuration).
REQ-013 SHALL have port o_tx  output  1  serial line, idle high.
REQ-014 SHALL have port o_busy  output  1  high when state != IDLE or FIFO not empty.
REQ-015 SHALL have port o_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-016 SHALL have port o_empty  output  1  FIFO holds 0 entries.
REQ-017 SHALL have port o_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-018 SHALL have port o_ovf  output  1  one-clock pulse on a rejected push.

Function
REQ-019 Push: i_wr & ~o_full stores i_data at the tail in the same edge; i_wr & o_full drops the data, pulses o_ovf, and leaves the FIFO unchanged, even when a pop occurs on the same edge.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP (plus BREAK, REQ-031); each non-IDLE state holds for whole i_ce periods.
REQ-021 IDLE: on i_ce with ~o_empty, pop the head into a DATA_W shift register; latch length, parity, odd, and stop2 for the whole frame; go to START. A push in the same cycle as an empty FIFO is popped on the next eligible tick, not the current one.
REQ-022 o_tx SHALL be 1 in IDLE, 0 in START, shreg[0] in DATA, the parity bit in PARITY, and 1 in STOP.
REQ-023 DATA: shift right one bit per i_ce; after the latched number of bits, go to PARITY if parity is latched, else STOP.
REQ-024 Parity = XOR of the transmitted data bits only (bits above the length are excluded) XOR latched odd.
REQ-025 STOP: lasts 1 tick, or 2 ticks if stop2 is latched; on the final stop tick, pop and go directly to START if the FIFO is non-empty (back-to-back frames, no idle bit), else go to IDLE.
REQ-026 Latency: a push into an empty FIFO with the FSM in IDLE drives o_tx low on the edge of the second i_ce after the push.
REQ-027 Config input changes mid-frame SHALL NOT affect the frame in progress.
REQ-028 Occupancy pointers wrap modulo FIFO_DEPTH; o_level stays within 0..FIFO_DEPTH; a simultaneous push and pop with non-full FIFO leaves o_level unchanged.
REQ-029 An illegal state encoding SHALL go to IDLE on the next clock.

Reset
REQ-030 While i_rst_n is low: state IDLE, FIFO emptied, o_tx=1, o_busy=0, o_full=0, o_empty=1, o_level=0, o_ovf=0, immediately and asynchronously, including mid-frame; operation resumes on the first clock after deassertion.

Configuration
REQ-031 With macro UART_TX_BREAK_EN defined: when i_break is high in IDLE on an i_ce, enter BREAK, hold o_tx=0 with no pops; on the first i_ce with i_break low, go to STOP for one tick, then follow REQ-025. A frame in progress completes before BREAK is entered. o_busy is high in BREAK.
REQ-032 Without UART_TX_BREAK_EN: the BREAK state and its logic are absent, the i_break port remains present and is ignored.

Verification
REQ-033 Length=3 (8 bits), no parity, stop2=0, push 0xA5 -> o_tx per tick: 0,1,0,1,0,0,1,0,1,1, then idle high.
REQ-034 Parity on, odd=0, length=2, push 0x07 -> 7 data bits 1,1,1,0,0,0,0, parity bit 1, one stop bit.
REQ-035 Push 3 bytes in consecutive clocks, stop2=1 -> three frames back-to-back with exactly 2 stop bits between them, o_busy falls only after the last stop bit.
REQ-036 Push FIFO_DEPTH+1 times with i_ce low -> o_full=1, o_level=8, one o_ovf pulse, the 9th byte is never transmitted.
REQ-037 Deassert i_rst_n mid-DATA -> o_tx=1 and o_level=0 before the next clock edge; a subsequent push transmits normally.
REQ-038 With UART_TX_BREAK_EN defined, raise i_break during a frame -> frame completes, o_tx low while i_break is high, then one high tick and the queued data resumes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a DATA_W x FIFO_DEPTH push FIFO, 5..12 data bits, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to enable the line-break state driven by i_break.
module uart_tx_fifo #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ce,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_wr,
    input  logic [2:0]                    i_length,
    input  logic                          i_stop2,
    input  logic                          i_parity,
    input  logic                          i_odd,
    input  logic                          i_break,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`endif

    state_t              r_state, w_next;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]       r_level;
    logic                r_ovf;
    logic [DATA_W-1:0]   r_shreg;
    logic [3:0]          r_nbits;
    logic [3:0]          r_cnt;
    logic                r_par_en, r_par, r_stop2;

    logic                w_full, w_empty, w_push, w_pop, w_tx, w_dpar;
    logic [DATA_W-1:0]   w_head;
    logic [3:0]          w_nbits;

`ifndef UART_TX_BREAK_EN
    logic w_unused_break;
    assign w_unused_break = i_break;
`endif

    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    // A push against a full FIFO is rejected even if a pop frees a slot on the same edge.
    assign w_push  = i_wr & ~w_full;
    assign w_head  = r_mem[r_rd_ptr];

    // Frame length clamp and parity over only the bits that will actually be sent.
    always_comb begin
        int unsigned bits;
        bits = 32'(i_length) + 32'd5;
        if (bits > 32'(DATA_W))
            bits = 32'(DATA_W);
        w_nbits = 4'(bits);
        w_dpar  = i_odd;
        for (int unsigned i = 0; i < 32'(DATA_W); i++)
            if (i < bits)
                w_dpar = w_dpar ^ w_head[i];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_tx   = 1'b1;
        case (r_state)
            IDLE: begin
                if (i_ce) begin
`ifdef UART_TX_BREAK_EN
                    if (i_break) begin
                        w_next = BREAK;
                    end else if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = START;
                    end
`else
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = START;
                    end
`endif
                end
            end
            START: begin
                w_tx = 1'b0;
                if (i_ce)
                    w_next = DATA;
            end
            DATA: begin
                w_tx = r_shreg[0];
                if (i_ce && (r_cnt == r_nbits - 4'd1))
                    w_next = r_par_en ? PARITY : STOP;
            end
            PARITY: begin
                w_tx = r_par;
                if (i_ce)
                    w_next = STOP;
            end
            STOP: begin
                if (i_ce && (!r_stop2 || (r_cnt != '0))) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = START;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                w_tx = 1'b0;
                if (i_ce && !i_break)
                    w_next = STOP;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    // Frame settings are captured at pop so mid-frame config changes cannot disturb it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg  <= '0;
            r_nbits  <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_stop2  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_pop) begin
                r_shreg  <= w_head;
                r_nbits  <= w_nbits;
                r_par_en <= i_parity;
                r_par    <= w_dpar;
                r_stop2  <= i_stop2;
            end else if ((r_state == DATA) && i_ce) begin
                r_shreg  <= {1'b0, r_shreg[DATA_W-1:1]};
            end
`ifdef UART_TX_BREAK_EN
            if ((r_state == BREAK) && (w_next == STOP))
                r_stop2 <= 1'b0;
`endif
            if (r_state != w_next)
                r_cnt <= '0;
            else if (i_ce)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= i_wr & w_full;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_tx    = w_tx;
    assign o_busy  = (r_state != IDLE) | ~w_empty;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;
    assign o_ovf   = r_ovf;

endmodule
